cipher_unload: RTL and testbench

CIPHER_UNLOAD -- requirements
Module: cipher_unload

---
 rtl/cipher_unload.sv | 174 +++++++++++++++++
 tb/tb_cipher_unload.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_unload.sv
// cipher_unload: reads the ciphertext word by word from the encryption block's
// cipher RAM and streams it out as bytes, MSB-first, over valid/ready.
// Optional feature macro: CIPHER_UNLOAD_CHECKSUM_EN appends one XOR checksum
// byte after the last data byte and moves byte_last onto it.
module cipher_unload #(
  parameter int parameter_set = 1,
  parameter int n = (parameter_set == 1) ? 3488 :
                    (parameter_set == 2) ? 4608 :
                    (parameter_set == 3) ? 6688 :
                    (parameter_set == 4) ? 6960 : 8192,
  parameter int m = (parameter_set == 1) ? 12 : 13,
  parameter int t = (parameter_set == 1) ? 64 :
                    (parameter_set == 2) ? 96 :
                    (parameter_set == 3) ? 128 :
                    (parameter_set == 4) ? 119 : 128,
  parameter int l = m * t,
  parameter int ram_depth = (l + 31) / 32,
  parameter int NB = (l + 7) / 8,
  localparam int AW = (ram_depth > 1) ? $clog2(ram_depth) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          rd_en_c,
  output logic [AW-1:0] addr_rd_c,
  input  logic [31:0]   cipher,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          byte_last,
  output logic          busy,
  output logic          done
);

  if (parameter_set < 1 || parameter_set > 5 || l > n) begin : g_bad_params
    $error("cipher_unload: unsupported parameter_set");
  end

`ifdef CIPHER_UNLOAD_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // Bytes carried by the final (possibly partial) word, and its last byte index.
  localparam int unsigned   LAST_BYTES = NB - 4 * (ram_depth - 1);
  localparam logic [1:0]    LAST_IDX   = 2'(LAST_BYTES - 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(ram_depth - 1);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, SEND, FIN} state_t;

  state_t      state;
  logic [31:0] word_q;
  logic [1:0]  byte_idx;
  logic        final_word;
  logic [1:0]  word_last_idx;
  logic        handshake;

`ifdef CIPHER_UNLOAD_CHECKSUM_EN
  logic [7:0]  xor_q;
  logic        chk_phase;
`endif

  assign final_word    = (addr_rd_c == LAST_ADDR);
  assign word_last_idx = final_word ? LAST_IDX : 2'd3;
  assign handshake     = byte_valid & byte_ready;

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    pick = w[31:24];
      2'd1:    pick = w[23:16];
      2'd2:    pick = w[15:8];
      default: pick = w[7:0];
    endcase
  endfunction

  // byte_last on a data byte only when no checksum byte follows it.
  function automatic logic data_last(input logic fw, input logic [1:0] idx);
    data_last = !CHK_EN && fw && (idx == LAST_IDX);
  endfunction

  // Unload FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_en_c    <= 1'b0;
      addr_rd_c  <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_q     <= '0;
      byte_idx   <= '0;
`ifdef CIPHER_UNLOAD_CHECKSUM_EN
      xor_q      <= '0;
      chk_phase  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            rd_en_c   <= 1'b1;
            busy      <= 1'b1;
            addr_rd_c <= '0;
`ifdef CIPHER_UNLOAD_CHECKSUM_EN
            xor_q     <= '0;
            chk_phase <= 1'b0;
`endif
          end
        end
        REQ: state <= LOAD;
        LOAD: begin
          word_q     <= cipher;
          byte_idx   <= '0;
          byte_out   <= cipher[31:24];
          byte_valid <= 1'b1;
          byte_last  <= data_last(final_word, 2'd0);
          state      <= SEND;
        end
        SEND: begin
          if (handshake) begin
`ifdef CIPHER_UNLOAD_CHECKSUM_EN
            xor_q <= xor_q ^ byte_out;
`endif
            // The checksum byte leaves byte_idx at the final data index, so
            // it falls through to the frame-end branch below.
            if (byte_idx != word_last_idx) begin
              byte_idx  <= byte_idx + 2'd1;
              byte_out  <= pick(word_q, byte_idx + 2'd1);
              byte_last <= data_last(final_word, byte_idx + 2'd1);
            end else if (!final_word) begin
              byte_valid <= 1'b0;
              byte_last  <= 1'b0;
              byte_out   <= '0;
              addr_rd_c  <= addr_rd_c + 1'b1;
              state      <= REQ;
            end else begin
`ifdef CIPHER_UNLOAD_CHECKSUM_EN
              if (!chk_phase) begin
                chk_phase <= 1'b1;
                byte_out  <= xor_q ^ byte_out;
                byte_last <= 1'b1;
              end else begin
                chk_phase  <= 1'b0;
                byte_valid <= 1'b0;
                byte_last  <= 1'b0;
                byte_out   <= '0;
                done       <= 1'b1;
                state      <= FIN;
              end
`else
              byte_valid <= 1'b0;
              byte_last  <= 1'b0;
              byte_out   <= '0;
              done       <= 1'b1;
              state      <= FIN;
`endif
            end
          end
        end
        FIN: begin
          rd_en_c <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_unload.sv
// tb_cipher_unload: randomized scoreboard bench for cipher_unload, set 1 and set 4.
`timescale 1ns/1ps
module tb_cipher_unload;

`ifdef CIPHER_UNLOAD_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int NB1 = 96;
  localparam int RD1 = 24;
  localparam int NB4 = 194;
  localparam int RD4 = 49;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start1, rd1, valid1, ready1, last1, busy1, done1;
  logic [4:0]  addr1;
  logic [31:0] cipher1;
  logic [7:0]  byte1;
  logic        start4, rd4, valid4, ready4, last4, busy4, done4;
  logic [5:0]  addr4;
  logic [31:0] cipher4;
  logic [7:0]  byte4;

  cipher_unload #(.parameter_set(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rd_en_c(rd1), .addr_rd_c(addr1),
    .cipher(cipher1), .byte_out(byte1), .byte_valid(valid1), .byte_ready(ready1),
    .byte_last(last1), .busy(busy1), .done(done1)
  );

  cipher_unload #(.parameter_set(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .rd_en_c(rd4), .addr_rd_c(addr4),
    .cipher(cipher4), .byte_out(byte4), .byte_valid(valid4), .byte_ready(ready4),
    .byte_last(last4), .busy(busy4), .done(done4)
  );

  // Cipher RAMs with one-cycle read latency
  logic [31:0] mem1 [RD1];
  logic [31:0] mem4 [RD4];
  always @(posedge clk) cipher1 <= rd1 ? mem1[addr1] : '0;
  always @(posedge clk) cipher4 <= rd4 ? mem4[addr4] : '0;

  logic [8:0] q1[$];
  logic [8:0] q4[$];
  int checks = 0;
  int errors = 0;
  int hs1 = 0, hs4 = 0, done_cnt1 = 0, done_cnt4 = 0, stalls1 = 0;
  int rmode1 = 0, rmode4 = 0, stall_base1 = 0, base4 = 0;
  bit hold1 = 0, hold4 = 0;
  logic [8:0] held1, held4;
  logic [15:0] tail4 = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Reference model: the frame is the RAM read as a big-endian byte string
  // truncated to NB bytes, optionally followed by the XOR of those bytes.
  task automatic push_exp1;
    logic [7:0] b;
    logic [7:0] x;
    x = '0;
    foreach (mem1[w])
      for (int j = 0; j < 4; j++)
        if (w * 4 + j < NB1) begin
          b = 8'(mem1[w] >> (8 * (3 - j)));
          x ^= b;
          q1.push_back({(CHK == 0) && (w * 4 + j == NB1 - 1), b});
        end
    if (CHK != 0) q1.push_back({1'b1, x});
  endtask

  task automatic push_exp4;
    logic [7:0] b;
    logic [7:0] x;
    x = '0;
    foreach (mem4[w])
      for (int j = 0; j < 4; j++)
        if (w * 4 + j < NB4) begin
          b = 8'(mem4[w] >> (8 * (3 - j)));
          x ^= b;
          q4.push_back({(CHK == 0) && (w * 4 + j == NB4 - 1), b});
        end
    if (CHK != 0) q4.push_back({1'b1, x});
  endtask

  task automatic fill1(input bit rnd);
    logic [7:0] v;
    foreach (mem1[i]) begin
      v = 8'(i);
      mem1[i] = rnd ? $urandom : {4{v}};
    end
  endtask

  // Pulse start and check the REQ entry and the 2-cycle valid latency.
  task automatic start_seq1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    check("dut1_req_addr", 32'(addr1), 32'd0);
    check("dut1_req_rd_busy_valid", 32'({rd1, busy1, valid1}), 32'b110);
    @(posedge clk); #1 check("dut1_load_valid", 32'(valid1), 32'd0);
    @(posedge clk); #1 check("dut1_first_valid", 32'(valid1), 32'd1);
  endtask

  task automatic frame1(input string name, input int mode, input bit spurious);
    int hs0, d0, st0, n;
    rmode1 = mode;
    hs0 = hs1; d0 = done_cnt1; st0 = stalls1; stall_base1 = hs1;
    push_exp1();
    start_seq1();
    n = 0;
    while (done_cnt1 == d0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      start1 = spurious && (hs1 - hs0 >= 10) && (hs1 - hs0 <= 11);
    end
    start1 = 1'b0;
    check({name, "_done_seen"}, 32'(done_cnt1 != d0), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check({name, "_done_count"}, 32'(done_cnt1 - d0), 32'd1);
    check({name, "_bytes"}, 32'(hs1 - hs0), 32'(NB1 + CHK));
    check({name, "_idle"}, 32'({busy1, rd1, valid1}), 32'd0);
    check({name, "_queue_drained"}, 32'(q1.size()), 32'd0);
    if (mode == 2) check({name, "_stall_cycles"}, 32'(stalls1 - st0), 32'd5);
  endtask

  // Sink ready drivers: 0 always ready, 1 random, 2 hold off 5 cycles at byte 2
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    ready1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode1)
        1: ready1 = ($urandom_range(0, 3) != 0);
        2: begin
          if (valid1 && (hs1 - stall_base1 == 2) && stall_cnt < 5) begin
            ready1 = 1'b0;
            stall_cnt++;
          end else ready1 = 1'b1;
        end
        default: ready1 = 1'b1;
      endcase
      if (rmode1 != 2) stall_cnt = 0;
    end
  end

  initial begin
    ready4 = 1'b0;
    forever begin
      @(posedge clk); #1;
      ready4 = (rmode4 == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks hold-while-stalled
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold1 = 0;
        hold4 = 0;
      end else begin
        if (hold1) check("dut1_hold", 32'({valid1, last1, byte1}), 32'({1'b1, held1}));
        hold1 = valid1 && !ready1;
        held1 = {last1, byte1};
        if (valid1 && !ready1) stalls1++;
        if (valid1 && ready1) begin
          hs1++;
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1_stream: got %03h, required no byte", {last1, byte1});
          end else check("dut1_stream", 32'({last1, byte1}), 32'(q1.pop_front()));
        end
        if (done1) begin
          done_cnt1++;
          check("dut1_done_queue_empty", 32'(q1.size()), 32'd0);
          check("dut1_done_valid_low", 32'(valid1), 32'd0);
        end

        if (hold4) check("dut4_hold", 32'({valid4, last4, byte4}), 32'({1'b1, held4}));
        hold4 = valid4 && !ready4;
        held4 = {last4, byte4};
        if (valid4 && ready4) begin
          if (hs4 - base4 == NB4 - 2) tail4[15:8] = byte4;
          if (hs4 - base4 == NB4 - 1) tail4[7:0] = byte4;
          hs4++;
          if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut4_stream: got %03h, required no byte", {last4, byte4});
          end else check("dut4_stream", 32'({last4, byte4}), 32'(q4.pop_front()));
        end
        if (done4) begin
          done_cnt4++;
          check("dut4_done_queue_empty", 32'(q4.size()), 32'd0);
        end
      end
    end
  end

  initial begin
    int hs0, d0, n;
    rst = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    foreach (mem1[i]) mem1[i] = '0;
    foreach (mem4[i]) mem4[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dut1_reset_outputs", 32'({rd1, addr1, byte1, valid1, last1, busy1, done1}), 32'd0);
    check("dut4_reset_outputs", 32'({rd4, addr4, byte4, valid4, last4, busy4, done4}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    fill1(1'b0);
    frame1("pattern", 0, 1'b0);
    check("pattern_final_addr", 32'(addr1), 32'd23);

    fill1(1'b1);
    frame1("backpressure", 2, 1'b0);

    fill1(1'b1);
    frame1("ignored_start", 1, 1'b1);

    // Reset while byte 40 is on the port
    fill1(1'b1);
    rmode1 = 0;
    hs0 = hs1; d0 = done_cnt1;
    push_exp1();
    start_seq1();
    n = 0;
    while (hs1 - hs0 < 40 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reached_byte40", 32'(hs1 - hs0), 32'd40);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_reset_outputs", 32'({rd1, addr1, byte1, valid1, last1, busy1, done1}), 32'd0);
    q1.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("abort_no_done", 32'(done_cnt1 - d0), 32'd0);

    fill1(1'b0);
    frame1("after_reset", 0, 1'b0);

    // Set 4: partial final word carrying two bytes
    foreach (mem4[i]) mem4[i] = $urandom;
    mem4[RD4 - 1] = 32'hABE00000;
    rmode4 = 1;
    hs0 = hs4; d0 = done_cnt4; base4 = hs4;
    push_exp4();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    check("dut4_req_addr", 32'(addr4), 32'd0);
    n = 0;
    while (done_cnt4 == d0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check("dut4_done_seen", 32'(done_cnt4 != d0), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("dut4_done_count", 32'(done_cnt4 - d0), 32'd1);
    check("dut4_bytes", 32'(hs4 - hs0), 32'(NB4 + CHK));
    check("dut4_tail_bytes", 32'(tail4), 32'h0000ABE0);
    check("dut4_final_addr", 32'(addr4), 32'd48);
    check("dut4_idle", 32'({busy4, rd4, valid4}), 32'd0);
    check("dut4_queue_drained", 32'(q4.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
